// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch reader.
package prefetch_pkg;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_RUN  = 2'd1,
        PF_HOLD = 2'd2
    } pf_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } pf_entry_t;

    // Cycles from address issue to mem_rdata_i being valid.
    localparam int PF_RAM_LATENCY = 2;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetched {data, address} entries with flush.
// The head is read straight from the storage registers, so it is stable while not popped.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  pf_entry_t        push_entry,
    input  logic             pop,
    output pf_entry_t        head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    pf_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_entry;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/instr_prefetch_reader.sv
// Instruction-port read initiator: issues sequential word reads to the RAM,
// buffers the returned words and hands them to the fetch stage.
module instr_prefetch_reader
    import prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_rdata_o,
    output logic [31:0]           instr_addr_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int LAT   = PF_RAM_LATENCY;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    pf_state_e             state_reg;
    pf_state_e             state_next;
    logic [ADDR_WIDTH-1:0] pc_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [LAT-1:0]        stage_vld_reg;
    logic [ADDR_WIDTH-1:0] stage_addr_reg [LAT];

    logic                  issue;
    logic [SUM_W-1:0]      inflight;
    logic [SUM_W-1:0]      credit_used;
    logic [CNT_W-1:0]      fifo_count;
    pf_entry_t             push_entry;
    pf_entry_t             head;
    logic                  unused_branch_bits;

    assign unused_branch_bits = ^{branch_addr_i[31:ADDR_WIDTH+2], branch_addr_i[1:0]};

    always_comb begin
        state_next = state_reg;
        if (branch_i) begin
            state_next = PF_RUN;
        end else begin
            case (state_reg)
                PF_RUN:  if (!req_i) state_next = PF_HOLD;
                PF_HOLD: if (req_i)  state_next = PF_RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SUM_W'(stage_vld_reg[i]);
        end
    end

    // Every outstanding read already owns a FIFO slot, so the buffer cannot overflow.
    assign credit_used = SUM_W'(fifo_count) + inflight;
    assign issue       = (state_reg == PF_RUN) && !branch_i &&
                         (credit_used < SUM_W'(FIFO_DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= PF_IDLE;
            pc_reg       <= '0;
            mem_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (branch_i) begin
                pc_reg <= branch_addr_i[ADDR_WIDTH+1:2];
            end else if (issue) begin
                pc_reg <= pc_reg + ADDR_WIDTH'(1);
            end
            if (issue) begin
                mem_addr_reg <= pc_reg;
            end
        end
    end

    // Branch kills every tracked read, so late data of the old stream never gets pushed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_vld_reg <= '0;
            for (int i = 0; i < LAT; i++) begin
                stage_addr_reg[i] <= '0;
            end
        end else begin
            stage_vld_reg     <= branch_i ? '0 : {stage_vld_reg[LAT-2:0], issue};
            stage_addr_reg[0] <= pc_reg;
            for (int i = 1; i < LAT; i++) begin
                stage_addr_reg[i] <= stage_addr_reg[i-1];
            end
        end
    end

    assign mem_en_o   = issue | stage_vld_reg[0];
    assign mem_addr_o = issue ? pc_reg : mem_addr_reg;

    assign push_entry = '{data: mem_rdata_i,
                          addr: 32'({stage_addr_reg[LAT-1], 2'b00})};

    prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .flush      (branch_i),
        .push       (stage_vld_reg[LAT-1]),
        .push_entry (push_entry),
        .pop        (instr_valid_o & instr_ready_i),
        .head       (head),
        .count      (fifo_count)
    );

    assign instr_valid_o = (fifo_count != '0);
    assign instr_rdata_o = head.data;
    assign instr_addr_o  = head.addr;

endmodule

// File: tb/tb_instr_prefetch_reader.sv
// Directed bench for instr_prefetch_reader with a two-cycle registered RAM model.
module tb_instr_prefetch_reader;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk_i         = 1'b0;
    logic          rst_ni        = 1'b0;
    logic          req_i         = 1'b0;
    logic          branch_i      = 1'b0;
    logic [31:0]   branch_addr_i = '0;
    logic          instr_ready_i = 1'b0;
    logic          instr_valid_o;
    logic [31:0]   instr_rdata_o;
    logic [31:0]   instr_addr_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i;

    logic [31:0]   ram_s1;
    logic [31:0]   ram_out;

    int checks = 0;
    int errors = 0;

    instr_prefetch_reader #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ram_word(input logic [AW-1:0] w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    // RAM: array read register plus output register, both advancing on mem_en_o.
    always @(posedge clk_i) begin
        if (mem_en_o) begin
            ram_s1  <= ram_word(mem_addr_o);
            ram_out <= ram_s1;
        end
    end
    assign mem_rdata_i = ram_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] baddr);
        chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
        chk({tag, "_addr"}, instr_addr_o, baddr);
        chk({tag, "_data"}, instr_rdata_o, ram_word(baddr[AW+1:2]));
    endtask

    task automatic chk_mem(input string tag, input logic en, input int addr);
        chk({tag, "_en"}, 32'(mem_en_o), 32'(en));
        if (en) chk({tag, "_addr"}, 32'(mem_addr_o), 32'(addr));
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset values
        req_i = 1'b1;
        repeat (3) cyc();
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_rdata", instr_rdata_o, 32'd0);
        chk("rst_addr", instr_addr_o, 32'd0);
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        #2 rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("idle%0d_valid", k), 32'(instr_valid_o), 32'd0);
            chk($sformatf("idle%0d_en", k), 32'(mem_en_o), 32'd0);
        end

        // Branch to 0x100, ready high: one instruction per cycle from t0+4
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0100; instr_ready_i = 1'b1;
        #1 chk("s1_br_en", 32'(mem_en_o), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            branch_i = 1'b0;
            #1;
            chk_mem($sformatf("s1_t%0d", k), 1'b1, 'h40 + k - 1);
            if (k <= 3) chk($sformatf("s1_t%0d_valid", k), 32'(instr_valid_o), 32'd0);
            else chk_head($sformatf("s1_t%0d", k), 32'h100 + 32'(4 * (k - 4)));
        end

        // Back-pressure: exactly DEPTH reads, head stable, then in-order drain
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0180; instr_ready_i = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            branch_i = 1'b0;
            if (k == 10) instr_ready_i = 1'b1;
            #1;
            if (k <= 10) begin
                chk($sformatf("s2_t%0d_en", k), 32'(mem_en_o), 32'(k <= 5));
                chk($sformatf("s2_t%0d_maddr", k), 32'(mem_addr_o),
                    (k <= 4) ? 32'('h60 + k - 1) : 32'h63);
            end
            if (k == 11) chk_mem("s2_reissue", 1'b1, 'h64);
            if (k >= 4 && k <= 10) chk_head($sformatf("s2_hold%0d", k), 32'h180);
            if (k >= 11) chk_head($sformatf("s2_drain%0d", k), 32'h180 + 32'(4 * (k - 10)));
        end

        // Branch with buffered entries and reads in flight: old stream never seen
        cyc();
        instr_ready_i = 1'b0;
        #1 chk_head("s3_pre", 32'h1A0);
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0200; instr_ready_i = 1'b1;
        #1 chk_head("s3_brcyc", 32'h1A0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            branch_i = 1'b0;
            #1;
            if (k <= 3) chk($sformatf("s3_t%0d_valid", k), 32'(instr_valid_o), 32'd0);
            else chk_head($sformatf("s3_t%0d", k), 32'h200 + 32'(4 * (k - 4)));
        end

        // Wrap-around from byte 0x3F8 (upper/low address bits ignored), then HOLD
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'hABCD_E3FB;
        for (int k = 1; k <= 18; k++) begin
            cyc();
            branch_i = 1'b0;
            if (k == 8)  req_i = 1'b0;
            if (k == 13) req_i = 1'b1;
            #1;
            if (k <= 8)       chk_mem($sformatf("s4_t%0d", k), 1'b1, (254 + k - 1) % 256);
            else if (k == 9)  chk_mem("s5_t9", 1'b1, 'h05);
            else if (k <= 13) chk_mem($sformatf("s5_t%0d", k), 1'b0, 0);
            else if (k == 14) chk_mem("s5_t14", 1'b1, 'h06);
            if (k >= 4 && k <= 11)
                chk_head($sformatf("s4_t%0d", k), 32'((32'h3F8 + 4 * (k - 4)) % 1024));
            else if (k >= 12 && k <= 16)
                chk($sformatf("s5_t%0d_valid", k), 32'(instr_valid_o), 32'd0);
            else if (k >= 17)
                chk_head($sformatf("s5_t%0d", k), 32'h018 + 32'(4 * (k - 17)));
        end

        // Asynchronous reset with entries buffered and both stages busy
        cyc();
        instr_ready_i = 1'b0;
        cyc();
        chk("s6_pre_valid", 32'(instr_valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(instr_valid_o), 32'd0);
        chk("s6_rst_rdata", instr_rdata_o, 32'd0);
        chk("s6_rst_addr", instr_addr_o, 32'd0);
        chk("s6_rst_en", 32'(mem_en_o), 32'd0);
        chk("s6_rst_maddr", 32'(mem_addr_o), 32'd0);
        #2 rst_ni = 1'b1;
        instr_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("s6_idle%0d_valid", k), 32'(instr_valid_o), 32'd0);
            chk($sformatf("s6_idle%0d_en", k), 32'(mem_en_o), 32'd0);
        end
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'h0000_0040;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            branch_i = 1'b0;
            #1;
            if (k <= 3) chk($sformatf("s6_t%0d_valid", k), 32'(instr_valid_o), 32'd0);
            else chk_head($sformatf("s6_t%0d", k), 32'h040 + 32'(4 * (k - 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
